truth_table_checker: RTL and testbench

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker_if.sv | 36 +++
 rtl/truth_table_checker.sv | 156 +++++++++++++++
 tb/tb_truth_table_checker.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// rtl/truth_table_checker_if.sv - vector/response bundle and result bundle for truth_table_checker
//
// Purpose : groups the checker's stimulus inputs and registered results.
// Signals : start, vld, a, b, c, f          - driven by the master (stimulus side)
//           busy, done, pass, err_cnt,
//           first_err_idx, first_err_vld,
//           coverage, captured, timeout     - driven by the slave (checker)
interface truth_table_checker_if;
  logic       start;
  logic       vld;
  logic       a;
  logic       b;
  logic       c;
  logic       f;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] err_cnt;
  logic [2:0] first_err_idx;
  logic       first_err_vld;
  logic [7:0] coverage;
  logic [7:0] captured;
  logic       timeout;

  modport master (
    output start, vld, a, b, c, f,
    input  busy, done, pass, err_cnt, first_err_idx, first_err_vld,
           coverage, captured, timeout
  );

  modport slave (
    input  start, vld, a, b, c, f,
    output busy, done, pass, err_cnt, first_err_idx, first_err_vld,
           coverage, captured, timeout
  );
endinterface

// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - checks a 3-input DUT response against a golden truth table
//
// Purpose : collects {a,b,c}/f samples in any order, compares each against
//           EXPECTED, and reports coverage, captured responses and errors.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - truth_table_checker_if.slave (start/vld/a/b/c/f in,
//                  busy/done/pass/err_cnt/first_err_*/coverage/captured/timeout out)
// Options : TT_CHECK_TIMEOUT_EN - builds a COLLECT cycle counter that ends the
//           run with timeout=1 after TIMEOUT_CYC cycles without full coverage.
module truth_table_checker #(
  parameter logic [7:0]  EXPECTED    = 8'b1000_0000,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_checker_if.slave bus
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_cnt_q, err_cnt_d;
  logic [2:0] first_err_idx_q, first_err_idx_d;
  logic       first_err_vld_q, first_err_vld_d;
  logic [7:0] coverage_q, coverage_d;
  logic [7:0] captured_q, captured_d;
  logic [2:0] idx;

`ifdef TT_CHECK_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cyc_q, cyc_d;
  logic          timeout_q, timeout_d;
`endif

  assign idx = {bus.a, bus.b, bus.c};

  always_comb begin
    state_d         = state_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    first_err_vld_d = first_err_vld_q;
    coverage_d      = coverage_q;
    captured_d      = captured_q;
    pass_d          = pass_q;
`ifdef TT_CHECK_TIMEOUT_EN
    cyc_d           = cyc_q;
    timeout_d       = timeout_q;
`endif

    if (bus.start) begin
      // start wins over vld in every state and always reopens a clean run
      state_d         = S_COLLECT;
      err_cnt_d       = 4'd0;
      first_err_idx_d = 3'd0;
      first_err_vld_d = 1'b0;
      coverage_d      = 8'h00;
      captured_d      = 8'h00;
      pass_d          = 1'b0;
`ifdef TT_CHECK_TIMEOUT_EN
      cyc_d           = '0;
      timeout_d       = 1'b0;
`endif
    end else if (state_q == S_COLLECT) begin
      if (bus.vld) begin
        coverage_d[idx] = 1'b1;
        captured_d[idx] = bus.f;
        if (bus.f != EXPECTED[idx]) begin
          if (err_cnt_q != 4'hF) begin
            err_cnt_d = err_cnt_q + 4'd1;
          end
          if (!first_err_vld_q) begin
            first_err_idx_d = idx;
            first_err_vld_d = 1'b1;
          end
        end
      end
`ifdef TT_CHECK_TIMEOUT_EN
      cyc_d = cyc_q + CW'(1);
`endif
      // completion is tested before timeout so a last sample on the
      // expiring cycle still yields a clean result
      if (coverage_d == 8'hFF) begin
        state_d = S_DONE;
        pass_d  = (err_cnt_d == 4'd0);
`ifdef TT_CHECK_TIMEOUT_EN
      end else if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
        state_d   = S_DONE;
        pass_d    = 1'b0;
        timeout_d = 1'b1;
`endif
      end
    end

    busy_d = (state_d == S_COLLECT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      err_cnt_q       <= 4'd0;
      first_err_idx_q <= 3'd0;
      first_err_vld_q <= 1'b0;
      coverage_q      <= 8'h00;
      captured_q      <= 8'h00;
`ifdef TT_CHECK_TIMEOUT_EN
      cyc_q           <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      first_err_vld_q <= first_err_vld_d;
      coverage_q      <= coverage_d;
      captured_q      <= captured_d;
`ifdef TT_CHECK_TIMEOUT_EN
      cyc_q           <= cyc_d;
      timeout_q       <= timeout_d;
`endif
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_idx = first_err_idx_q;
  assign bus.first_err_vld = first_err_vld_q;
  assign bus.coverage      = coverage_q;
  assign bus.captured      = captured_q;
`ifdef TT_CHECK_TIMEOUT_EN
  assign bus.timeout       = timeout_q;
`else
  assign bus.timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// tb/tb_truth_table_checker.sv - self-checking bench for truth_table_checker
module tb_truth_table_checker;
  localparam int TO_CYC = 16;
`ifdef TT_CHECK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst;
  int   nchk;
  int   npass;

  truth_table_checker_if bus();

  truth_table_checker #(
    .EXPECTED   (8'b1000_0000),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: the run as a set of seen indices plus error bookkeeping
  bit       m_run;
  bit       m_done;
  bit       m_pass;
  bit       m_to;
  int       m_err;
  int       m_first;
  bit       m_fvld;
  bit [7:0] m_seen;
  bit [7:0] m_cap;
  int       m_cyc;

  wire [27:0] dut_vec = {bus.busy, bus.done, bus.pass, bus.err_cnt,
                         bus.first_err_idx, bus.first_err_vld,
                         bus.coverage, bus.captured, bus.timeout};

  function automatic bit golden(input int i);
    return ((i >> 2) & (i >> 1) & i & 1) != 0;   // 3-input AND
  endfunction

  function automatic logic [27:0] model_vec();
    int e;
    e = (m_err > 15) ? 15 : m_err;
    return {m_run, m_done, m_pass, 4'(e), 3'(m_first), m_fvld, m_seen, m_cap, m_to};
  endfunction

  task automatic model_clear();
    m_run = 0; m_done = 0; m_pass = 0; m_to = 0; m_err = 0;
    m_first = 0; m_fvld = 0; m_seen = 0; m_cap = 0; m_cyc = 0;
  endtask

  // advance model and DUT by one clock using the inputs currently driven
  task automatic tick();
    int i;
    i = {bus.a, bus.b, bus.c};
    if (bus.start) begin
      model_clear();
      m_run = 1;
    end else if (m_run) begin
      if (bus.vld) begin
        m_seen[i] = 1'b1;
        m_cap[i]  = bus.f;
        if (bus.f != golden(i)) begin
          m_err++;
          if (!m_fvld) begin m_first = i; m_fvld = 1; end
        end
      end
      m_cyc++;
      if (m_seen == 8'hFF) begin
        m_run = 0; m_done = 1; m_pass = (m_err == 0);
      end else if (TO_EN && m_cyc == TO_CYC) begin
        m_run = 0; m_done = 1; m_pass = 0; m_to = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit s, input bit v, input int i, input bit fv);
    bus.start = s; bus.vld = v;
    {bus.a, bus.b, bus.c} = 3'(i);
    bus.f = fv;
    tick();
    bus.start = 0; bus.vld = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    nchk++;
    if (dut_vec !== 28'h0) $display("FAIL reset_state: got %h expected %h", dut_vec, 28'h0);
    else npass++;
    for (int k = 0; k < 8; k++) drive(0, 1, k, 1);
    nchk++;
    if (dut_vec !== model_vec() || bus.coverage !== 8'h00)
      $display("FAIL idle_vld_ignored: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask

  task automatic test_all_pass();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 8; k++) begin
      drive(0, 1, k, golden(k));
      nchk++;
      if (dut_vec !== model_vec())
        $display("FAIL all_pass_step%0d: got %h expected %h", k, dut_vec, model_vec());
      else npass++;
    end
    nchk++;
    if ({bus.done, bus.pass, bus.err_cnt, bus.coverage, bus.captured} !== {1'b1, 1'b1, 4'd0, 8'hFF, 8'h80})
      $display("FAIL all_pass_final: got done=%b pass=%b err=%0d cov=%h cap=%h expected 1 1 0 ff 80",
               bus.done, bus.pass, bus.err_cnt, bus.coverage, bus.captured);
    else npass++;
    // DONE holds and ignores vld
    for (int k = 0; k < 3; k++) drive(0, 1, k, ~golden(k));
    nchk++;
    if (dut_vec !== model_vec() || bus.err_cnt !== 4'd0)
      $display("FAIL done_hold: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask

  task automatic test_single_err();
    drive(1, 0, 0, 0);   // restart from DONE
    for (int k = 0; k < 8; k++) drive(0, 1, k, (k == 5) ? 1'b1 : golden(k));
    nchk++;
    if (dut_vec !== model_vec() ||
        {bus.pass, bus.err_cnt, bus.first_err_idx, bus.first_err_vld, bus.captured} !==
        {1'b0, 4'd1, 3'd5, 1'b1, 8'hA0})
      $display("FAIL single_err: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask

  task automatic test_repeat();
    int order[9] = '{7, 7, 3, 0, 1, 2, 4, 5, 6};
    drive(1, 0, 0, 0);
    for (int k = 0; k < 9; k++) begin
      drive(0, 1, order[k], (order[k] == 7) ? 1'b0 : golden(order[k]));
      if (k == 7) begin
        nchk++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1)
          $display("FAIL repeat_not_done: got done=%b busy=%b expected 0 1", bus.done, bus.busy);
        else npass++;
      end
    end
    nchk++;
    if (dut_vec !== model_vec() ||
        {bus.done, bus.err_cnt, bus.first_err_idx} !== {1'b1, 4'd2, 3'd7})
      $display("FAIL repeat_final: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask

  task automatic test_rst_mid();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(0, 1, k, golden(k));
    #2 rst = 1'b1;
    model_clear();
    #1;
    nchk++;
    if (dut_vec !== 28'h0) $display("FAIL rst_async: got %h expected %h", dut_vec, 28'h0);
    else npass++;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 6, 0);
    drive(0, 1, 7, 1);
    nchk++;
    if (dut_vec !== 28'h0) $display("FAIL rst_stays_idle: got %h expected %h", dut_vec, 28'h0);
    else npass++;
  endtask

  task automatic test_start_with_vld();
    drive(1, 0, 0, 0);
    drive(0, 1, 2, 1);
    drive(0, 1, 4, 0);
    drive(1, 1, 6, 1);
    nchk++;
    if (dut_vec !== model_vec() ||
        {bus.busy, bus.coverage, bus.err_cnt, bus.first_err_vld} !== {1'b1, 8'h00, 4'd0, 1'b0})
      $display("FAIL start_with_vld: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask

  task automatic test_saturate();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive(0, 1, 7, 0);
    nchk++;
    if (dut_vec !== model_vec() || bus.err_cnt !== 4'hF)
      $display("FAIL saturate: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask

  task automatic test_random();
    int fails;
    fails = 0;
    for (int r = 0; r < 12; r++) begin
      drive(1, 0, 0, 0);
      for (int k = 0; k < 60; k++) begin
        int i;
        i = $urandom_range(7);
        drive(($urandom_range(39) == 0), ($urandom_range(1) == 1), i,
              ($urandom_range(4) == 0) ? ~golden(i) : golden(i));
        nchk++;
        if (dut_vec !== model_vec()) begin
          if (fails < 10) $display("FAIL random_r%0d_c%0d: got %h expected %h", r, k, dut_vec, model_vec());
          fails++;
        end else npass++;
      end
    end
  endtask

`ifdef TT_CHECK_TIMEOUT_EN
  task automatic test_timeout();
    drive(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) drive(0, 1, k, golden(k));
    for (int k = 0; k < 12; k++) drive(0, 0, 0, 0);
    nchk++;
    if (dut_vec !== model_vec() ||
        {bus.done, bus.timeout, bus.pass, bus.coverage} !== {1'b1, 1'b1, 1'b0, 8'h7F})
      $display("FAIL timeout: got %h expected %h", dut_vec, model_vec());
    else npass++;
    // completing sample on the expiring cycle wins
    drive(1, 0, 0, 0);
    for (int k = 0; k < 7; k++) drive(0, 1, k, golden(k));
    for (int k = 0; k < TO_CYC - 8; k++) drive(0, 0, 0, 0);
    drive(0, 1, 7, 1);
    nchk++;
    if (dut_vec !== model_vec() ||
        {bus.done, bus.timeout, bus.pass} !== {1'b1, 1'b0, 1'b1})
      $display("FAIL timeout_tie: got %h expected %h", dut_vec, model_vec());
    else npass++;
  endtask
`endif

  initial begin
    nchk = 0; npass = 0;
    rst = 1'b1;
    bus.start = 0; bus.vld = 0; bus.a = 0; bus.b = 0; bus.c = 0; bus.f = 0;
    test_reset();
    test_all_pass();
    test_single_err();
    test_repeat();
    test_rst_mid();
    test_start_with_vld();
    test_saturate();
`ifdef TT_CHECK_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
